// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall priority and bubble insertion.
// Optional HAZARD_STATS_EN adds a saturating load-use bubble counter; otherwise bubble_count reads zero.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_instr_rs,
  input  logic [4:0]  id_instr_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_write_reg_addr,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_read_data_1,
  input  logic [31:0] id_read_data_2,
  input  logic [31:0] id_imm,
  input  logic        ex_flush,
  input  logic        ex_stall,
  output logic        id_ex_valid,
  output logic [4:0]  id_ex_instr_rs,
  output logic [4:0]  id_ex_instr_rt,
  output logic        id_ex_uses_rt,
  output logic [4:0]  id_ex_write_reg_addr,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_mem_to_reg,
  output logic        id_ex_alu_src,
  output logic [3:0]  id_ex_alu_op,
  output logic [31:0] id_ex_read_data_1,
  output logic [31:0] id_ex_read_data_2,
  output logic [31:0] id_ex_imm,
  output logic        id_stall,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic        uses_rt;
    logic [4:0]  write_reg_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] imm;
  } stage_t;

  stage_t stage_q, stage_d;
  logic   hazard;
  logic   rs_match, rt_match;

  always_comb begin
    rs_match = (stage_q.write_reg_addr == id_instr_rs);
    rt_match = id_uses_rt & (stage_q.write_reg_addr == id_instr_rt);
    hazard   = id_valid & stage_q.valid & stage_q.mem_read &
               (stage_q.write_reg_addr != 5'd0) & (rs_match | rt_match);
    id_stall = hazard & ~ex_flush & ~ex_stall;
  end

  // Flush and bubble both squash control/identity fields; operand data is left as-is.
  always_comb begin
    stage_d = stage_q;
    if (ex_flush || (!ex_stall && hazard)) begin
      stage_d.valid          = 1'b0;
      stage_d.reg_write      = 1'b0;
      stage_d.mem_read       = 1'b0;
      stage_d.mem_write      = 1'b0;
      stage_d.mem_to_reg     = 1'b0;
      stage_d.write_reg_addr = 5'd0;
      stage_d.instr_rs       = 5'd0;
      stage_d.instr_rt       = 5'd0;
    end else if (!ex_stall) begin
      stage_d.valid          = id_valid;
      stage_d.instr_rs       = id_instr_rs;
      stage_d.instr_rt       = id_instr_rt;
      stage_d.uses_rt        = id_uses_rt;
      stage_d.write_reg_addr = id_write_reg_addr;
      stage_d.reg_write      = id_valid & id_reg_write;
      stage_d.mem_read       = id_valid & id_mem_read;
      stage_d.mem_write      = id_valid & id_mem_write;
      stage_d.mem_to_reg     = id_valid & id_mem_to_reg;
      stage_d.alu_src        = id_valid & id_alu_src;
      stage_d.alu_op         = id_alu_op;
      stage_d.read_data_1    = id_read_data_1;
      stage_d.read_data_2    = id_read_data_2;
      stage_d.imm            = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign id_ex_valid          = stage_q.valid;
  assign id_ex_instr_rs       = stage_q.instr_rs;
  assign id_ex_instr_rt       = stage_q.instr_rt;
  assign id_ex_uses_rt        = stage_q.uses_rt;
  assign id_ex_write_reg_addr = stage_q.write_reg_addr;
  assign id_ex_reg_write      = stage_q.reg_write;
  assign id_ex_mem_read       = stage_q.mem_read;
  assign id_ex_mem_write      = stage_q.mem_write;
  assign id_ex_mem_to_reg     = stage_q.mem_to_reg;
  assign id_ex_alu_src        = stage_q.alu_src;
  assign id_ex_alu_op         = stage_q.alu_op;
  assign id_ex_read_data_1    = stage_q.read_data_1;
  assign id_ex_read_data_2    = stage_q.read_data_2;
  assign id_ex_imm            = stage_q.imm;

`ifdef HAZARD_STATS_EN
  logic [15:0] bubble_count_q, bubble_count_d;

  // id_stall is exactly the edge on which a load-use bubble goes in.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (id_stall && (bubble_count_q != 16'hFFFF))
      bubble_count_d = bubble_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_count_q <= 16'h0000;
    else        bubble_count_q <= bubble_count_d;
  end

  assign bubble_count = bubble_count_q;
`else
  assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: hazard stall, bubble, flush, stall hold, reset and counter behaviour.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt;
  logic [4:0]  id_instr_rs, id_instr_rt, id_write_reg_addr;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0]  id_alu_op;
  logic [31:0] id_read_data_1, id_read_data_2, id_imm;
  logic        ex_flush, ex_stall;
  logic        id_ex_valid, id_ex_uses_rt;
  logic [4:0]  id_ex_instr_rs, id_ex_instr_rt, id_ex_write_reg_addr;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_read_data_1, id_ex_read_data_2, id_ex_imm;
  logic        id_stall;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;
  int stats_en;
  logic [15:0] exp_bc;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_instr_rs(id_instr_rs), .id_instr_rt(id_instr_rt), .id_uses_rt(id_uses_rt),
    .id_write_reg_addr(id_write_reg_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
    .ex_flush(ex_flush), .ex_stall(ex_stall),
    .id_ex_valid(id_ex_valid), .id_ex_instr_rs(id_ex_instr_rs), .id_ex_instr_rt(id_ex_instr_rt),
    .id_ex_uses_rt(id_ex_uses_rt), .id_ex_write_reg_addr(id_ex_write_reg_addr),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_read_data_1(id_ex_read_data_1), .id_ex_read_data_2(id_ex_read_data_2),
    .id_ex_imm(id_ex_imm), .id_stall(id_stall), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] wa, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic as, input logic [3:0] op,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid = v; id_instr_rs = rs; id_instr_rt = rt; id_uses_rt = ur;
    id_write_reg_addr = wa; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = m2r; id_alu_src = as; id_alu_op = op;
    id_read_data_1 = d1; id_read_data_2 = d2; id_imm = imm;
    #1;
  endtask

  task automatic drive_lw(input logic [4:0] wa, input logic [4:0] rs, input logic [31:0] d1);
    drive(1, rs, 5'd0, 0, wa, 1, 1, 0, 1, 1, 4'h2, d1, 32'h0, 32'h10);
  endtask

  task automatic drive_alu(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                           input logic [4:0] wa, input logic [31:0] d1);
    drive(1, rs, rt, ur, wa, 1, 0, 0, 0, 0, 4'h0, d1, 32'h22, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble_expected();
    exp_bc = exp_bc + stats_en[15:0];
  endtask

  initial begin
`ifdef HAZARD_STATS_EN
    stats_en = 1;
`else
    stats_en = 0;
`endif
    exp_bc = 16'h0;
    ex_flush = 0; ex_stall = 0;
    rst_n = 1'b1;
    drive(1, 5'd7, 5'd8, 1, 5'd9, 1, 1, 1, 1, 1, 4'hF, 32'hDEAD, 32'hBEEF, 32'hCAFE);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", id_ex_valid, 0);
    chk("rst_wa", id_ex_write_reg_addr, 0);
    chk("rst_mr", id_ex_mem_read, 0);
    chk("rst_d1", id_ex_read_data_1, 0);
    chk("rst_imm", id_ex_imm, 0);
    chk("rst_stall", id_stall, 0);
    chk("rst_bc", bubble_count, 0);

    // First edge after release is a plain load of lw $5
    drive_lw(5'd5, 5'd2, 32'h100);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("lw_valid", id_ex_valid, 1);
    chk("lw_wa", id_ex_write_reg_addr, 5);
    chk("lw_mr", id_ex_mem_read, 1);
    chk("lw_op", id_ex_alu_op, 4'h2);
    chk("lw_d1", id_ex_read_data_1, 32'h100);
    chk("lw_imm", id_ex_imm, 32'h10);

    // Load-use on rs: one stall, one bubble, then the add enters EX
    drive_alu(5'd5, 5'd6, 1, 5'd7, 32'h11);
    chk("lu_stall", id_stall, 1);
    tick(); bubble_expected();
    chk("lu_bub_valid", id_ex_valid, 0);
    chk("lu_bub_mr", id_ex_mem_read, 0);
    chk("lu_bub_rw", id_ex_reg_write, 0);
    chk("lu_bub_wa", id_ex_write_reg_addr, 0);
    chk("lu_bub_rs", id_ex_instr_rs, 0);
    chk("lu_bub_d1_hold", id_ex_read_data_1, 32'h100);
    chk("lu_bub_op_hold", id_ex_alu_op, 4'h2);
    chk("lu_stall_drop", id_stall, 0);
    chk("lu_bc", bubble_count, exp_bc);
    tick();
    chk("lu_add_valid", id_ex_valid, 1);
    chk("lu_add_rs", id_ex_instr_rs, 5);
    chk("lu_add_rt", id_ex_instr_rt, 6);
    chk("lu_add_wa", id_ex_write_reg_addr, 7);
    chk("lu_add_d1", id_ex_read_data_1, 32'h11);
    chk("lu_add_d2", id_ex_read_data_2, 32'h22);

    // rt match only counts when the instruction reads rt
    drive_lw(5'd5, 5'd1, 32'h200);
    tick();
    drive_alu(5'd3, 5'd5, 1, 5'd8, 32'h33);
    chk("rt_used_stall", id_stall, 1);
    drive(1, 5'd3, 5'd5, 0, 5'd8, 1, 0, 0, 0, 1, 4'h1, 32'h33, 32'h0, 32'h44);
    chk("addi_no_stall", id_stall, 0);
    tick();
    chk("addi_valid", id_ex_valid, 1);
    chk("addi_wa", id_ex_write_reg_addr, 8);
    chk("addi_as", id_ex_alu_src, 1);
    chk("addi_imm", id_ex_imm, 32'h44);

    // Destination $0 never hazards
    drive_lw(5'd0, 5'd1, 32'h300);
    tick();
    chk("r0_mr", id_ex_mem_read, 1);
    drive_alu(5'd0, 5'd0, 1, 5'd4, 32'h55);
    chk("r0_no_stall", id_stall, 0);
    tick();
    chk("r0_load_wa", id_ex_write_reg_addr, 4);

    // Hazard together with flush: flush bubble, no stall, no count
    drive_lw(5'd5, 5'd1, 32'h400);
    tick();
    drive_alu(5'd5, 5'd0, 0, 5'd6, 32'h66);
    ex_flush = 1; #1;
    chk("fl_stall", id_stall, 0);
    tick();
    ex_flush = 0;
    chk("fl_valid", id_ex_valid, 0);
    chk("fl_wa", id_ex_write_reg_addr, 0);
    chk("fl_mr", id_ex_mem_read, 0);
    chk("fl_d1_hold", id_ex_read_data_1, 32'h400);
    chk("fl_bc", bubble_count, exp_bc);

    // Downstream stall for three cycles with a hazard pending
    drive_lw(5'd9, 5'd1, 32'hAAA);
    tick();
    drive_alu(5'd9, 5'd0, 0, 5'd3, 32'h77);
    ex_stall = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_stall", id_stall, 0);
      tick();
      chk("st_valid", id_ex_valid, 1);
      chk("st_wa", id_ex_write_reg_addr, 9);
      chk("st_mr", id_ex_mem_read, 1);
      chk("st_d1", id_ex_read_data_1, 32'hAAA);
    end
    ex_stall = 0; #1;
    chk("st_rel_stall", id_stall, 1);
    tick(); bubble_expected();
    chk("st_rel_valid", id_ex_valid, 0);
    chk("st_rel_bc", bubble_count, exp_bc);
    tick();
    chk("st_rel_load", id_ex_write_reg_addr, 3);

    // Back-to-back dependent loads each take one bubble
    drive_lw(5'd10, 5'd1, 32'h500);
    tick();
    drive_lw(5'd11, 5'd10, 32'h600);
    chk("bb1_stall", id_stall, 1);
    tick(); bubble_expected();
    chk("bb1_bub", id_ex_valid, 0);
    tick();
    chk("bb1_load_wa", id_ex_write_reg_addr, 11);
    drive_alu(5'd2, 5'd11, 1, 5'd12, 32'h88);
    chk("bb2_stall", id_stall, 1);
    tick(); bubble_expected();
    chk("bb2_bub", id_ex_valid, 0);
    chk("bb2_bc", bubble_count, exp_bc);
    tick();
    chk("bb2_load_wa", id_ex_write_reg_addr, 12);

    // Invalid decode slot: no hazard, control bits load as zero
    drive_lw(5'd13, 5'd1, 32'h700);
    tick();
    drive(0, 5'd13, 5'd13, 1, 5'd14, 1, 1, 1, 1, 1, 4'h5, 32'h990, 32'h991, 32'h992);
    chk("inv_no_stall", id_stall, 0);
    tick();
    chk("inv_valid", id_ex_valid, 0);
    chk("inv_rw", id_ex_reg_write, 0);
    chk("inv_mr", id_ex_mem_read, 0);
    chk("inv_mw", id_ex_mem_write, 0);
    chk("inv_as", id_ex_alu_src, 0);
    chk("inv_d1", id_ex_read_data_1, 32'h990);

    // Reset pulse mid-hold clears everything at once
    drive_lw(5'd9, 5'd1, 32'hBBB);
    tick();
    drive_alu(5'd9, 5'd0, 0, 5'd15, 32'hCC);
    ex_stall = 1;
    tick(); tick();
    chk("mh_frozen", id_ex_write_reg_addr, 9);
    #2; rst_n = 1'b0; #1;
    chk("mh_rst_valid", id_ex_valid, 0);
    chk("mh_rst_wa", id_ex_write_reg_addr, 0);
    chk("mh_rst_d1", id_ex_read_data_1, 0);
    chk("mh_rst_stall", id_stall, 0);
    chk("mh_rst_bc", bubble_count, 0);
    exp_bc = 16'h0;
    rst_n = 1'b1; ex_stall = 0; #1;
    tick();
    chk("mh_post_valid", id_ex_valid, 1);
    chk("mh_post_rs", id_ex_instr_rs, 9);
    chk("mh_post_wa", id_ex_write_reg_addr, 15);

`ifdef HAZARD_STATS_EN
    // Self-dependent lw alternates bubble/load; 65537 bubbles must saturate
    drive_lw(5'd5, 5'd5, 32'h1);
    tick();
    for (int i = 0; i < 65537; i++) begin
      tick(); tick();
    end
    chk("sat_bc", bubble_count, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: id_valid  input  1  decode slot holds a live instruction.
REQ-004 SHALL: id_instr_rs, id_instr_rt  input  5 each  decoded source register fields.
REQ-005 SHALL: id_uses_rt  input  1  instruction reads rt as an operand (R-type, store, branch).
REQ-006 SHALL: id_write_reg_addr  input  5  destination register.
REQ-007 SHALL: id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  input  1 each  decoded control bits.
REQ-008 SHALL: id_alu_op  input  4  ALU operation code.
REQ-009 SHALL: id_read_data_1, id_read_data_2, id_imm  input  32 each  register-file operands and sign-extended immediate.
REQ-010 SHALL: ex_flush  input  1  taken branch/jump resolved in EX; squash the decode slot.
REQ-011 SHALL: ex_stall  input  1  downstream hold; freeze this stage.
REQ-012 SHALL: id_ex_* outputs  output  widths as inputs  registered copies of every id_* field above, plus id_ex_valid (1).
REQ-013 SHALL: id_stall  output  1  load-use hazard; PC and IF/ID hold this cycle.
REQ-014 SHALL: bubble_count  output  16  load-use bubbles inserted (see Configuration).

Function
REQ-015 SHALL: hazard = id_valid & id_ex_valid & id_ex_mem_read & (id_ex_write_reg_addr != 0) & ((id_ex_write_reg_addr == id_instr_rs) | (id_uses_rt & id_ex_write_reg_addr == id_instr_rt)).
REQ-016 SHALL: id_stall = hazard & !ex_flush & !ex_stall; purely combinational from registered state and current inputs.
REQ-017 SHALL: per-edge update priority: ex_flush > ex_stall > hazard > load.
REQ-018 SHALL: flush and bubble both clear id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, and zero id_ex_write_reg_addr, id_ex_instr_rs, id_ex_instr_rt; data fields hold.
REQ-019 SHALL: ex_stall (without flush) holds every id_ex_* register unchanged.
REQ-020 SHALL: load captures all id_* fields; id_ex_valid <= id_valid; if id_valid=0, control bits load as 0.
REQ-021 SHALL: latency decode->EX is exactly 1 cycle; a load-use adds exactly 1 bubble (bubble clears id_ex_mem_read, so hazard drops next cycle).
REQ-022 SHALL: ex_flush with a pending hazard inserts a flush bubble, does not assert id_stall, does not count.
REQ-023 SHALL: back-to-back loads each produce an independent single bubble when dependent.
REQ-024 SHALL: destination $0 never causes a hazard.

Reset
REQ-025 SHALL: rst_n low asynchronously clears every id_ex_* register, id_ex_valid, and bubble_count to 0; id_stall evaluates to 0.
REQ-026 SHALL: first edge after rst_n release performs a normal load.

Configuration
REQ-027 SHALL: macro HAZARD_STATS_EN defined -> bubble_count increments by 1 on each edge a load-use bubble is inserted (REQ-017 hazard branch), saturating at 16'hFFFF.
REQ-028 SHALL: HAZARD_STATS_EN undefined -> no counter logic; bubble_count tied to 16'h0000; port retained.

Verification
REQ-029 SHALL: lw $5 in EX (mem_read=1, dest=5), decode add rs=5 -> id_stall=1 one cycle, id_ex_valid=0 bubble, add enters EX next cycle, id_stall=0.
REQ-030 SHALL: lw dest=5, decode addi rs=3 rt=5 id_uses_rt=0 -> no stall, addi loads directly.
REQ-031 SHALL: lw dest=0, decode rs=0 -> no stall.
REQ-032 SHALL: hazard and ex_flush same cycle -> id_stall=0, stage flushed, bubble_count unchanged.
REQ-033 SHALL: ex_stall=1 for 3 cycles with hazard present -> id_ex_* frozen, id_stall=0, then bubble on release.
REQ-034 SHALL: rst_n pulsed low mid-hold -> all outputs 0 immediately; with HAZARD_STATS_EN, 0xFFFF+1 bubbles -> bubble_count stays 16'hFFFF.
